// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register rename state
// (busy bit + producing ROB tag), same-cycle commit-to-read bypass and flush.
// Optional branch checkpoints are built when RENAME_REGFILE_CKPT_EN is defined;
// otherwise the ckpt_* inputs are ignored and recovery is by flush_in only.
module rename_regfile #(
   parameter  int XLEN       = 32,
   parameter  int NREG       = 32,
   parameter  int ROB_IDX_W  = 4,
   parameter  int NUM_RD     = 2,
   parameter  int NCKPT      = 4,
   localparam int REG_IDX_W  = $clog2(NREG),
   localparam int CKPT_IDX_W = $clog2(NCKPT)
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          rdy_in,
   input  logic [NUM_RD*REG_IDX_W-1:0]   rd_idx_in,
   output logic [NUM_RD*XLEN-1:0]        rd_val_out,
   output logic [NUM_RD-1:0]             rd_busy_out,
   output logic [NUM_RD*ROB_IDX_W-1:0]   rd_tag_out,
   input  logic                          issue_en_in,
   input  logic [REG_IDX_W-1:0]          issue_rd_in,
   input  logic [ROB_IDX_W-1:0]          issue_tag_in,
   input  logic                          commit_en_in,
   input  logic [REG_IDX_W-1:0]          commit_rd_in,
   input  logic [ROB_IDX_W-1:0]          commit_tag_in,
   input  logic [XLEN-1:0]               commit_val_in,
   input  logic                          flush_in,
   input  logic                          ckpt_save_in,
   input  logic                          ckpt_restore_in,
   input  logic [CKPT_IDX_W-1:0]         ckpt_id_in
);

   logic [XLEN-1:0]      r_val  [NREG];
   logic                 r_busy [NREG];
   logic [ROB_IDX_W-1:0] r_tag  [NREG];

   logic                 w_nxt_busy [NREG];
   logic [ROB_IDX_W-1:0] w_nxt_tag  [NREG];
   logic [REG_IDX_W-1:0] w_ridx;

   logic w_commit;
   logic w_issue;
   logic w_flush;
   logic w_restore;

   // Writes to x0 are dropped here so register 0 never leaves its reset state.
   assign w_commit = rdy_in && commit_en_in && (commit_rd_in != '0);
   assign w_issue  = rdy_in && issue_en_in  && (issue_rd_in  != '0);
   assign w_flush  = rdy_in && flush_in;

`ifdef RENAME_REGFILE_CKPT_EN
   logic                 r_snap_busy [NCKPT][NREG];
   logic [ROB_IDX_W-1:0] r_snap_tag  [NCKPT][NREG];
   logic                 w_save;

   assign w_restore = rdy_in && ckpt_restore_in;
   assign w_save    = rdy_in && ckpt_save_in;
`else
   logic w_unused_ckpt;

   assign w_restore     = 1'b0;
   assign w_unused_ckpt = ^{ckpt_save_in, ckpt_restore_in, ckpt_id_in};
`endif

   // Next rename state: restore base, then commit clear, then flush or issue.
   // The commit is applied on top of a restored table; issue overrides commit.
   always_comb begin
      for (int unsigned i = 0; i < NREG; i++) begin
         w_nxt_busy[i] = r_busy[i];
         w_nxt_tag[i]  = r_tag[i];
`ifdef RENAME_REGFILE_CKPT_EN
         if (w_restore) begin
            w_nxt_busy[i] = r_snap_busy[ckpt_id_in][i];
            w_nxt_tag[i]  = r_snap_tag[ckpt_id_in][i];
         end
`endif
         if (w_commit && (commit_rd_in == REG_IDX_W'(i)) &&
             w_nxt_busy[i] && (w_nxt_tag[i] == commit_tag_in)) begin
            w_nxt_busy[i] = 1'b0;
         end
         if (!w_restore) begin
            if (w_flush) begin
               w_nxt_busy[i] = 1'b0;
            end else if (w_issue && (issue_rd_in == REG_IDX_W'(i))) begin
               w_nxt_busy[i] = 1'b1;
               w_nxt_tag[i]  = issue_tag_in;
            end
         end
      end
   end

   // Architectural values and live rename table; frozen while rdy_in is low.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_val[i]  <= '0;
            r_busy[i] <= 1'b0;
            r_tag[i]  <= '0;
         end
      end else if (rdy_in) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (w_commit && (commit_rd_in == REG_IDX_W'(i))) begin
               r_val[i] <= commit_val_in;
            end
            r_busy[i] <= w_nxt_busy[i];
            r_tag[i]  <= w_nxt_tag[i];
         end
      end
   end

`ifdef RENAME_REGFILE_CKPT_EN
   // Snapshot slots: save captures the post-update table; commits retire
   // matching entries in every other slot so they survive a later restore.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int unsigned s = 0; s < NCKPT; s++) begin
            for (int unsigned i = 0; i < NREG; i++) begin
               r_snap_busy[s][i] <= 1'b0;
               r_snap_tag[s][i]  <= '0;
            end
         end
      end else begin
         for (int unsigned s = 0; s < NCKPT; s++) begin
            for (int unsigned i = 0; i < NREG; i++) begin
               if (w_save && (ckpt_id_in == CKPT_IDX_W'(s))) begin
                  r_snap_busy[s][i] <= w_nxt_busy[i];
                  r_snap_tag[s][i]  <= w_nxt_tag[i];
               end else if (w_commit && (commit_rd_in == REG_IDX_W'(i)) &&
                            r_snap_busy[s][i] &&
                            (r_snap_tag[s][i] == commit_tag_in)) begin
                  r_snap_busy[s][i] <= 1'b0;
               end
            end
         end
      end
   end
`endif

   // Combinational read ports with x0 forced to zero and commit bypass.
   always_comb begin
      rd_val_out  = '0;
      rd_busy_out = '0;
      rd_tag_out  = '0;
      w_ridx      = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         w_ridx = rd_idx_in[k*REG_IDX_W +: REG_IDX_W];
         if (w_ridx != '0) begin
            rd_tag_out[k*ROB_IDX_W +: ROB_IDX_W] = r_tag[w_ridx];
            if (w_commit && (w_ridx == commit_rd_in) && r_busy[w_ridx] &&
                (r_tag[w_ridx] == commit_tag_in)) begin
               rd_val_out[k*XLEN +: XLEN] = commit_val_in;
               rd_busy_out[k]             = 1'b0;
            end else begin
               rd_val_out[k*XLEN +: XLEN] = r_val[w_ridx];
               rd_busy_out[k]             = r_busy[w_ridx];
            end
         end
      end
   end

endmodule

// File: tb/tb_rename_regfile.sv
// Testbench for rename_regfile: directed scenarios plus randomized traffic
// checked against a behavioural register/rename model.
module tb_rename_regfile;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int RW    = 4;
   localparam int NRD   = 2;
   localparam int NCK   = 4;
   localparam int IW    = 5;
   localparam int CW    = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                rdy;
   logic [NRD*IW-1:0]   rd_idx;
   logic [NRD*XLEN-1:0] rd_val;
   logic [NRD-1:0]      rd_busy;
   logic [NRD*RW-1:0]   rd_tag;
   logic                issue_en;
   logic [IW-1:0]       issue_rd;
   logic [RW-1:0]       issue_tag;
   logic                commit_en;
   logic [IW-1:0]       commit_rd;
   logic [RW-1:0]       commit_tag;
   logic [XLEN-1:0]     commit_val;
   logic                flush;
   logic                ck_save;
   logic                ck_restore;
   logic [CW-1:0]       ck_id;

   int n_tests = 0;
   int n_fail  = 0;

   rename_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_IDX_W(RW), .NUM_RD(NRD), .NCKPT(NCK)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
      .rd_idx_in(rd_idx), .rd_val_out(rd_val), .rd_busy_out(rd_busy), .rd_tag_out(rd_tag),
      .issue_en_in(issue_en), .issue_rd_in(issue_rd), .issue_tag_in(issue_tag),
      .commit_en_in(commit_en), .commit_rd_in(commit_rd), .commit_tag_in(commit_tag),
      .commit_val_in(commit_val), .flush_in(flush),
      .ckpt_save_in(ck_save), .ckpt_restore_in(ck_restore), .ckpt_id_in(ck_id)
   );

   always #5 clk = ~clk;

   // Reference model: plain arrays holding what the register file should contain.
   logic [XLEN-1:0] m_val  [NREG];
   bit              m_busy [NREG];
   logic [RW-1:0]   m_tag  [NREG];
   bit              s_busy [NCK][NREG];
   logic [RW-1:0]   s_tag  [NCK][NREG];

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
         for (int s = 0; s < NCK; s++) begin s_busy[s][i] = 0; s_tag[s][i] = '0; end
      end
   endtask

   function automatic bit commit_valid();
      return rdy && commit_en && (commit_rd != 0);
   endfunction

   // Expected read of port k given the current register contents and inputs.
   task automatic model_read(input int k, output logic [XLEN-1:0] v, output logic b,
                             output logic [RW-1:0] t);
      int idx;
      idx = int'(rd_idx[k*IW +: IW]);
      if (idx == 0) begin
         v = '0; b = 0; t = '0;
      end else begin
         t = m_tag[idx];
         if (commit_valid() && idx == int'(commit_rd) && m_busy[idx] && m_tag[idx] == commit_tag) begin
            v = commit_val; b = 0;
         end else begin
            v = m_val[idx]; b = m_busy[idx];
         end
      end
   endtask

   // Clock-edge update of the model from the currently applied inputs.
   task automatic model_clock();
      bit            nb [NREG];
      logic [RW-1:0] nt [NREG];
      bit            restore;
      int            cr;
      int            id;
      if (!rdy) return;
      cr = int'(commit_rd);
      id = int'(ck_id);
      restore = 0;
      nb = m_busy;
      nt = m_tag;
`ifdef RENAME_REGFILE_CKPT_EN
      restore = ck_restore;
      if (restore) begin nb = s_busy[id]; nt = s_tag[id]; end
`endif
      if (commit_valid()) begin
         m_val[cr] = commit_val;
         if (nb[cr] && nt[cr] == commit_tag) nb[cr] = 0;
`ifdef RENAME_REGFILE_CKPT_EN
         for (int s = 0; s < NCK; s++)
            if (s_busy[s][cr] && s_tag[s][cr] == commit_tag) s_busy[s][cr] = 0;
`endif
      end
      if (!restore) begin
         if (flush) begin
            for (int i = 0; i < NREG; i++) nb[i] = 0;
         end else if (issue_en && issue_rd != 0) begin
            nb[int'(issue_rd)] = 1; nt[int'(issue_rd)] = issue_tag;
         end
      end
`ifdef RENAME_REGFILE_CKPT_EN
      if (ck_save) begin s_busy[id] = nb; s_tag[id] = nt; end
`endif
      m_busy = nb;
      m_tag  = nt;
   endtask

   task automatic idle();
      issue_en = 0; commit_en = 0; flush = 0; ck_save = 0; ck_restore = 0; rdy = 1;
   endtask

   // Advance one clock; inputs are applied and sampled around the negedge.
   task automatic step();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0; idle(); rd_idx = {5'd0, 5'd5};
      issue_rd = 0; issue_tag = 0; commit_rd = 0; commit_tag = 0; commit_val = 0; ck_id = 0;
      model_reset();
      @(negedge clk); #1;
      n_tests++; if (rd_val[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_val got %h exp 0", rd_val[31:0]); end
      n_tests++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", rd_busy[0]); end
      n_tests++; if (rd_tag[3:0] !== 4'h0) begin n_fail++; $display("FAIL reset_tag got %h exp 0", rd_tag[3:0]); end
      @(negedge clk); rst_n = 1; @(negedge clk);
   endtask

   task automatic test_issue_commit_bypass();
      idle(); issue_en = 1; issue_rd = 3; issue_tag = 0; step(); idle();
      rd_idx = {5'd0, 5'd3}; #1;
      n_tests++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL issue_busy got %b exp 1", rd_busy[0]); end
      n_tests++; if (rd_tag[3:0] !== 4'h0) begin n_fail++; $display("FAIL issue_tag got %h exp 0", rd_tag[3:0]); end
      commit_en = 1; commit_rd = 3; commit_tag = 0; commit_val = 32'hDEADBEEF; #1;
      n_tests++; if (rd_val[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_val got %h exp deadbeef", rd_val[31:0]); end
      n_tests++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got %b exp 0", rd_busy[0]); end
      step(); idle(); step(); #1;
      n_tests++; if (rd_val[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL commit_hold got %h/%b exp deadbeef/0", rd_val[31:0], rd_busy[0]); end
   endtask

   task automatic test_younger_rename();
      idle(); issue_en = 1; issue_rd = 7; issue_tag = 2; step();
      issue_tag = 5; step(); idle();
      commit_en = 1; commit_rd = 7; commit_tag = 2; commit_val = 32'h11; rd_idx = {5'd7, 5'd0}; #1;
      n_tests++; if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL stale_nobypass got busy %b exp 1", rd_busy[1]); end
      step(); idle(); #1;
      n_tests++; if (rd_val[63:32] !== 32'h11) begin n_fail++; $display("FAIL stale_val got %h exp 11", rd_val[63:32]); end
      n_tests++; if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL stale_busy got %b exp 1", rd_busy[1]); end
      n_tests++; if (rd_tag[7:4] !== 4'h5) begin n_fail++; $display("FAIL stale_tag got %h exp 5", rd_tag[7:4]); end
   endtask

   task automatic test_reg0();
      idle(); issue_en = 1; issue_rd = 0; issue_tag = 1;
      commit_en = 1; commit_rd = 0; commit_tag = 1; commit_val = 32'h55; rd_idx = '0; step(); idle(); #1;
      n_tests++; if (rd_val[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || rd_tag[3:0] !== 4'h0) begin
         n_fail++; $display("FAIL x0 got %h/%b/%h exp 0/0/0", rd_val[31:0], rd_busy[0], rd_tag[3:0]); end
   endtask

   task automatic test_flush();
      idle(); issue_en = 1; issue_rd = 9; issue_tag = 3; step();
      issue_rd = 4; issue_tag = 1; flush = 1; step(); idle();
      rd_idx = {5'd9, 5'd4}; #1;
      n_tests++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL flush_x4 got busy %b exp 0", rd_busy[0]); end
      n_tests++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL flush_x9 got busy %b exp 0", rd_busy[1]); end
   endtask

   task automatic test_issue_commit_same_rd();
      idle(); issue_en = 1; issue_rd = 10; issue_tag = 6; step();
      issue_tag = 7; commit_en = 1; commit_rd = 10; commit_tag = 6; commit_val = 32'hCAFE0001;
      step(); idle(); rd_idx = {5'd0, 5'd10}; #1;
      n_tests++; if (rd_val[31:0] !== 32'hCAFE0001 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'h7) begin
         n_fail++; $display("FAIL same_rd got %h/%b/%h exp cafe0001/1/7", rd_val[31:0], rd_busy[0], rd_tag[3:0]); end
   endtask

   task automatic test_stall();
      idle(); rdy = 0; issue_en = 1; issue_rd = 11; issue_tag = 2;
      commit_en = 1; commit_rd = 12; commit_tag = 0; commit_val = 32'h99; step(); idle();
      rd_idx = {5'd12, 5'd11}; #1;
      n_tests++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL stall_issue got busy %b exp 0", rd_busy[0]); end
      n_tests++; if (rd_val[63:32] !== 32'h0) begin n_fail++; $display("FAIL stall_commit got %h exp 0", rd_val[63:32]); end
   endtask

`ifdef RENAME_REGFILE_CKPT_EN
   task automatic test_ckpt();
      idle(); issue_en = 1; issue_rd = 2; issue_tag = 3; step(); idle();
      ck_save = 1; ck_id = 1; step(); idle();
      issue_en = 1; issue_rd = 2; issue_tag = 6; step(); idle();
      commit_en = 1; commit_rd = 2; commit_tag = 3; commit_val = 32'h42; step(); idle();
      ck_restore = 1; ck_id = 1; step(); idle(); rd_idx = {5'd0, 5'd2}; #1;
      n_tests++; if (rd_busy[0] !== 1'b0 || rd_val[31:0] !== 32'h42) begin
         n_fail++; $display("FAIL ckpt_restore got %h/%b exp 42/0", rd_val[31:0], rd_busy[0]); end
   endtask
`endif

   task automatic test_random();
      logic [XLEN-1:0] ev;
      logic            eb;
      logic [RW-1:0]   et;
      for (int c = 0; c < 400; c++) begin
         rdy        = ($urandom_range(0, 9) != 0);
         issue_en   = $urandom_range(0, 1);
         issue_rd   = IW'($urandom_range(0, 7));
         issue_tag  = RW'($urandom_range(0, 3));
         commit_en  = $urandom_range(0, 1);
         commit_rd  = IW'($urandom_range(0, 7));
         commit_tag = RW'($urandom_range(0, 3));
         commit_val = $urandom;
         flush      = ($urandom_range(0, 19) == 0);
         ck_save    = ($urandom_range(0, 7) == 0);
         ck_restore = ($urandom_range(0, 11) == 0);
         ck_id      = CW'($urandom_range(0, NCK - 1));
         for (int k = 0; k < NRD; k++) rd_idx[k*IW +: IW] = IW'($urandom_range(0, 7));
         #1;
         for (int k = 0; k < NRD; k++) begin
            model_read(k, ev, eb, et);
            n_tests++; if (rd_val[k*XLEN +: XLEN] !== ev) begin n_fail++;
               $display("FAIL rand_val cyc%0d port%0d got %h exp %h", c, k, rd_val[k*XLEN +: XLEN], ev); end
            n_tests++; if (rd_busy[k] !== eb) begin n_fail++;
               $display("FAIL rand_busy cyc%0d port%0d got %b exp %b", c, k, rd_busy[k], eb); end
            n_tests++; if (rd_tag[k*RW +: RW] !== et) begin n_fail++;
               $display("FAIL rand_tag cyc%0d port%0d got %h exp %h", c, k, rd_tag[k*RW +: RW], et); end
         end
         step();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_issue_commit_bypass();
      test_younger_rename();
      test_reg0();
      test_flush();
      test_issue_commit_same_rd();
      test_stall();
`ifdef RENAME_REGFILE_CKPT_EN
      test_ckpt();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with per-register rename status (busy bit plus ROB tag) for the out-of-order core. It sits between issue, which reads operands and renames `rd`, and ROB commit, which retires results. It adds over the previous generation:
- configurable register count, word width, ROB-tag width and read-port count;
- an explicit busy bit, so ROB index 0 is a valid tag;
- same-cycle commit-to-read bypass;
- optional branch checkpoints for selective recovery.

## Interface
- `XLEN`, 32, data word width
- `NREG`, 32, architectural register count; `REG_IDX_W = $clog2(NREG)`
- `ROB_IDX_W`, 4, ROB tag width
- `NUM_RD`, 2, read ports (operand lookups per cycle)
- `NCKPT`, 4, checkpoint slots (used only with the macro); `CKPT_IDX_W = $clog2(NCKPT)`
- `clk_in` input 1 — clock, all state on rising edge
- `rst_n_in` input 1 — asynchronous, active-low reset
- `rdy_in` input 1 — when low, no state changes; read outputs remain valid
- `rd_idx_in` input NUM_RD*REG_IDX_W — packed read indices, port k at bits [k*REG_IDX_W +: REG_IDX_W]
- `rd_val_out` output NUM_RD*XLEN — packed register values
- `rd_busy_out` output NUM_RD — register awaits an in-flight result
- `rd_tag_out` output NUM_RD*ROB_IDX_W — producing ROB tag, valid only when busy
- `issue_en_in` input 1 — rename `issue_rd_in` to `issue_tag_in`
- `issue_rd_in` input REG_IDX_W
- `issue_tag_in` input ROB_IDX_W
- `commit_en_in` input 1 — retire a register-writing result; caller filters non-writing instructions
- `commit_rd_in` input REG_IDX_W
- `commit_tag_in` input ROB_IDX_W
- `commit_val_in` input XLEN
- `flush_in` input 1 — misprediction; drop all speculative renames
- `ckpt_save_in` input 1 — macro builds only; snapshot rename table into slot `ckpt_id_in`
- `ckpt_restore_in` input 1 — macro builds only; restore slot `ckpt_id_in`
- `ckpt_id_in` input CKPT_IDX_W

## Operation
- State:
  - `val[NREG]` (XLEN bits each);
  - `busy[NREG]`;
  - `tag[NREG]` (ROB_IDX_W bits each);
  - with the macro, also `snap_busy[NCKPT][NREG]` and `snap_tag[NCKPT][NREG]`.
- Reset (`rst_n_in` low, asynchronous): all `val`, `busy` and `tag` bits are 0, and all snapshot busy bits are 0. Outputs are combinational, so they read 0/0/0 immediately after reset.
- Register 0:
  - reads always return value 0, busy 0, tag 0;
  - issue and commit targeting index 0 are ignored.
- Issue: `busy[rd] <= 1`, `tag[rd] <= issue_tag_in`.
- Commit:
  - `val[rd] <= commit_val_in` unconditionally;
  - `busy[rd] <= 0` only if `busy[rd]` is set and `tag[rd] == commit_tag_in`;
  - a mismatched tag means a younger rename exists, and busy stays set.
- Bypass: a read port whose index equals a valid commit `rd` (nonzero), with busy set and a matching tag, outputs `commit_val_in` with busy 0 in the same cycle.
- Simultaneous issue and commit on the same `rd`: the commit value is written, and busy/tag take the issue values (the issue wins).
- Flush: clears every `busy` bit; `val` is unaffected. This has priority over an issue in the same cycle (the issue is dropped). The commit value write still occurs.

## Timing
- Reads are combinational with zero latency; issue and commit effects are visible on reads from the next cycle (except the commit bypass, which is visible in the same cycle).
- One issue and one commit are accepted per cycle, with no handshake and no backpressure.
- A save in the same cycle as an issue captures the state *after* that issue's update.
- A restore has priority over both issue and flush in the same cycle.
- A commit in the same cycle as a restore is applied on top of the restored table.
- Reset asserted mid-operation aborts everything, and pending snapshots are lost.

## Configuration
- `RENAME_REGFILE_CKPT_EN` defined:
  - Save copies `busy`/`tag` into slot `ckpt_id_in`.
  - Restore loads `busy`/`tag` from that slot.
  - Every commit also clears the busy bit in each snapshot whose entry for `rd` is busy with a matching tag, so commits between save and restore are not lost.
  - `flush_in` still clears all busy bits.
- Not defined:
  - No snapshot storage is built.
  - `ckpt_*` inputs are ignored.
  - Recovery is by `flush_in` only.

## Test plan
- Reset, then read x5 on port 0 -> val 0, busy 0, tag 0.
- Issue rd=3 tag=0, next cycle read x3 -> busy 1, tag 0. Then commit rd=3 tag=0 val=0xDEADBEEF -> same-cycle bypass shows 0xDEADBEEF with busy 0, and the value is held in following cycles.
- Issue rd=7 tag=2, then issue rd=7 tag=5, then commit rd=7 tag=2 val=0x11 -> val 0x11, busy stays 1, tag 5.
- Issue rd=0 tag=1 and commit rd=0 val=0x55 -> x0 reads 0/0/0.
- Issue rd=4 tag=1 and flush in the same cycle -> x4 not busy; an earlier rd=9 rename is also cleared.
- Macro on: issue rd=2 tag=3, save slot 1, issue rd=2 tag=6, commit rd=2 tag=3 val=0x42, restore slot 1 -> x2 busy 0, val 0x42.
